tx_byte_sequencer: RTL and testbench
====================================

// Module: tx_byte_sequencer
// PURPOSE
//   Transmit-side counterpart of the receive byte counter in the packet processor.
//   Takes a packet length and start pulse, fetches bytes from the TX packet buffer
//   in order, and hands them one at a time to the downstream serializer over a
//   valid/ready handshake. Counts bytes sent and pulses tx_done after the last byte.
// PARAMETERS
//   CNT_WIDTH  4  width of pkt_len, count and buf_rd_addr; max packet = 2**CNT_WIDTH-1 bytes
// PORTS
//   clk          in   1          system clock, all logic on rising edge
//   rst          in   1          synchronous, active-high reset
//   start        in   1          1-cycle request to send a packet; sampled in IDLE only
//   pkt_len      in   CNT_WIDTH  packet length in bytes; latched when start is accepted
//   abort        in   1          cancel the packet in progress
//   buf_data     in   8          TX buffer read data, valid 1 cycle after buf_rd_en
//   buf_rd_en    out  1          TX buffer read strobe
//   buf_rd_addr  out  CNT_WIDTH  TX buffer byte index (= count)
//   tx_data      out  8          byte to serializer
//   tx_valid     out  1          tx_data valid
//   tx_ready     in   1          serializer accepts tx_data this cycle
//   byte_sent    out  1          1-cycle pulse per accepted byte
//   count        out  CNT_WIDTH  bytes sent in current/last packet
//   busy         out  1          high in any state other than IDLE
//   tx_done      out  1          1-cycle pulse after last byte accepted
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; tx_data=8'h00; latched length=0.
//   States: IDLE, FETCH, WAIT, SEND, DONE.
//   IDLE : start & pkt_len!=0 -> latch pkt_len, count<=0, go FETCH.
//          start with pkt_len==0 ignored (no busy, no tx_done).
//   FETCH: buf_rd_en=1, buf_rd_addr=count for exactly one cycle -> WAIT.
//   WAIT : capture buf_data into tx_data, tx_valid<=1 -> SEND.
//   SEND : tx_valid=1, tx_data held stable until tx_ready=1.
//          On tx_valid&tx_ready: byte_sent=1 that cycle, count<=count+1, tx_valid<=0;
//          if count+1 == latched len -> DONE, else -> FETCH.
//   DONE : tx_done=1 for one cycle -> IDLE. count keeps final value until next
//          accepted start.
//   Throughput: 3 cycles per byte when tx_ready held high (FETCH, WAIT, SEND).
//   First tx_valid rises 2 cycles after start is sampled.
//   start outside IDLE ignored; pkt_len changes after acceptance ignored.
//   abort (any non-IDLE state): next cycle state=IDLE, tx_valid=0, buf_rd_en=0,
//     count<=0, no tx_done. abort in the same SEND cycle as a handshake: abort
//     wins; byte_sent still pulses for that cycle (serializer already took the
//     byte), count cleared. abort in IDLE: no effect.
//   rst has priority over abort and start in every state, including mid-packet.
//   count never wraps: max len 2**CNT_WIDTH-1 ends the packet at count=len.
// TESTING
//   1. rst high 2 cycles -> all outputs 0, busy=0; start ignored while rst=1.
//   2. pkt_len=3, buffer {A1,B2,C3}, tx_ready=1 -> tx_data A1,B2,C3 in order,
//      3 byte_sent pulses 3 cycles apart, count=3, tx_done 1 cycle later, busy=0.
//   3. pkt_len=2, tx_ready low 5 cycles on byte 0 -> tx_data/tx_valid stable for
//      all 5 cycles; exactly 2 byte_sent pulses; tx_done once.
//   4. pkt_len=15 (max), tx_ready=1 -> buf_rd_addr 0..14, count ends at 15, no
//      wrap; start pulsed mid-packet has no effect.
//   5. pkt_len=4, abort after 2nd byte_sent -> next cycle busy=0, tx_valid=0,
//      count=0, no tx_done; a new start with pkt_len=1 then completes normally.
//   6. start with pkt_len=0 -> busy stays 0, no buf_rd_en, no tx_done.

Source files
------------

// File: rtl/tx_byte_sequencer.sv
// tx_byte_sequencer
//   Fetches pkt_len bytes from the TX packet buffer, in order, and hands them one at a
//   time to the serializer over a valid/ready handshake. Each byte takes three states:
//   FETCH (read strobe), WAIT (buffer latency, capture data) and SEND (handshake).
//   When the last byte is accepted, tx_done pulses for one cycle.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         request to send a packet; only sampled in IDLE
//   pkt_len       packet length in bytes, latched when start is accepted
//   abort         cancels the packet in progress
//   buf_data      buffer read data, valid one cycle after buf_rd_en
//   buf_rd_en     buffer read strobe
//   buf_rd_addr   buffer byte index (equals count)
//   tx_data       byte to the serializer
//   tx_valid      tx_data valid
//   tx_ready      serializer accepts tx_data this cycle
//   byte_sent     one-cycle pulse per accepted byte
//   count         bytes sent in the current or last packet
//   busy          high in any state other than IDLE
//   tx_done       one-cycle pulse after the last byte is accepted
module tx_byte_sequencer #(
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] pkt_len,
  input  logic                 abort,
  input  logic [7:0]           buf_data,
  output logic                 buf_rd_en,
  output logic [CNT_WIDTH-1:0] buf_rd_addr,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 byte_sent,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StSend,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;

  // count never exceeds len, which fits in CNT_WIDTH bits, so this cannot overflow.
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    buf_rd_en  = 1'b0;
    byte_sent  = 1'b0;
    tx_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A zero-length request is silently dropped.
        if (start && (pkt_len != '0)) begin
          len_d   = pkt_len;
          count_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        buf_rd_en = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        tx_data_d  = buf_data;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_valid_q && tx_ready) begin
          byte_sent  = 1'b1;
          count_d    = count_inc;
          tx_valid_d = 1'b0;
          state_d    = (count_inc == len_q) ? StDone : StFetch;
        end
      end
      StDone: begin
        tx_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides the normal transition; byte_sent is left alone because the
    // serializer has already taken the byte if a handshake happened this cycle.
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      count_d    = '0;
      tx_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign buf_rd_addr = count_q;
  assign count       = count_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_tx_byte_sequencer.sv
module tb_tx_byte_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pkt_len;
  logic       abort;
  logic [7:0] buf_data;
  logic       buf_rd_en;
  logic [3:0] buf_rd_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       byte_sent;
  logic [3:0] count;
  logic       busy;
  logic       tx_done;

  tx_byte_sequencer #(.CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pkt_len    (pkt_len),
    .abort      (abort),
    .buf_data   (buf_data),
    .buf_rd_en  (buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .byte_sent  (byte_sent),
    .count      (count),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // TX packet buffer: synchronous read, data one cycle after the strobe.
  logic [7:0] mem [16];
  always @(posedge clk) if (buf_rd_en) buf_data <= mem[buf_rd_addr];

  // Observation of the serializer side and the buffer side.
  logic [7:0] got_q [$];
  logic [3:0] addr_q [$];
  int         done_cnt;
  int         rd_cnt;
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_sent) got_q.push_back(tx_data);
      if (buf_rd_en) begin
        addr_q.push_back(buf_rd_addr);
        rd_cnt++;
      end
      if (tx_done) done_cnt++;
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic reset_mon();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
    rd_cnt   = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  // Leaves the bench settled in the first FETCH cycle of the packet.
  task automatic start_pkt(input logic [3:0] len);
    step();
    start   = 1'b1;
    pkt_len = len;
    settle();
    step();
    start = 1'b0;
    settle();
  endtask

  // Runs until tx_done is seen (or the budget expires); ends settled in the DONE cycle.
  task automatic wait_done(input int budget, input bit rnd_ready, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
      settle();
      if (tx_done) seen = 1'b1;
    end
  endtask

  // Expected bytes are simply the first len buffer entries, in order.
  task automatic chk_bytes(input string tag, input int len);
    chk({tag, "_nbytes"}, got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++) chk({tag, "_byte"}, got_q[i], mem[i]);
  endtask

  bit seen;
  bit hit;

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    pkt_len  = 4'd3;
    abort    = 1'b0;
    tx_ready = 1'b1;
    reset_mon();

    // Reset, with a start request held throughout.
    repeat (2) step();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_count", count, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_sent", byte_sent, 0);
    step();
    rst   = 1'b0;
    start = 1'b0;
    settle();
    chk("post_rst_busy", busy, 0);

    // Three bytes, cycle-exact: FETCH, WAIT, SEND per byte, then DONE.
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;
    reset_mon();
    start_pkt(4'd3);
    for (int b = 0; b < 3; b++) begin
      chk("p3_fetch_rd_en", buf_rd_en, 1);
      chk("p3_fetch_addr", buf_rd_addr, b);
      chk("p3_fetch_busy", busy, 1);
      step();
      settle();
      chk("p3_wait_valid", tx_valid, 0);
      step();
      settle();
      chk("p3_send_valid", tx_valid, 1);
      chk("p3_send_data", tx_data, mem[b]);
      chk("p3_send_sent", byte_sent, 1);
      chk("p3_send_count", count, b);
      step();
      settle();
    end
    chk("p3_done", tx_done, 1);
    chk("p3_done_count", count, 3);
    step();
    settle();
    chk("p3_idle_busy", busy, 0);
    chk("p3_idle_done", tx_done, 0);
    chk("p3_idle_count", count, 3);
    chk_bytes("p3", 3);
    chk("p3_done_cnt", done_cnt, 1);

    // Back-pressure: serializer stalls five cycles on byte 0.
    fill_mem();
    reset_mon();
    start_pkt(4'd2);
    tx_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (tx_valid) hit = 1'b1;
      else begin
        step();
        settle();
      end
    end
    chk("bp_valid_seen", hit, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", tx_valid, 1);
      chk("bp_hold_data", tx_data, mem[0]);
      chk("bp_hold_sent", byte_sent, 0);
      step();
      settle();
    end
    tx_ready = 1'b1;
    wait_done(40, 1'b0, seen);
    chk("bp_done_seen", seen, 1);
    step();
    settle();
    chk_bytes("bp", 2);
    chk("bp_done_cnt", done_cnt, 1);

    // Maximum length; a start pulse mid-packet must be ignored.
    fill_mem();
    reset_mon();
    start_pkt(4'd15);
    repeat (7) step();
    start   = 1'b1;
    pkt_len = 4'd5;
    step();
    start = 1'b0;
    wait_done(100, 1'b0, seen);
    chk("max_done_seen", seen, 1);
    chk("max_count", count, 15);
    step();
    settle();
    chk("max_idle_busy", busy, 0);
    chk("max_final_count", count, 15);
    chk_bytes("max", 15);
    chk("max_naddr", addr_q.size(), 15);
    for (int i = 0; i < 15 && i < addr_q.size(); i++) chk("max_addr", addr_q[i], i);
    chk("max_done_cnt", done_cnt, 1);

    // Abort in the cycle after the second byte is accepted.
    fill_mem();
    reset_mon();
    start_pkt(4'd4);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (byte_sent && count == 4'd1) hit = 1'b1;
      else begin
        step();
        settle();
      end
    end
    chk("ab_second_byte", hit, 1);
    step();
    abort = 1'b1;
    settle();
    step();
    abort = 1'b0;
    settle();
    chk("ab_busy", busy, 0);
    chk("ab_valid", tx_valid, 0);
    chk("ab_count", count, 0);
    chk("ab_done", tx_done, 0);
    chk("ab_nbytes", got_q.size(), 2);
    chk("ab_done_cnt", done_cnt, 0);
    reset_mon();
    start_pkt(4'd1);
    wait_done(20, 1'b0, seen);
    chk("ab_new_done", seen, 1);
    chk("ab_new_count", count, 1);
    step();
    settle();
    chk_bytes("ab_new", 1);

    // Abort together with a handshake: byte still counted as sent, count cleared.
    fill_mem();
    reset_mon();
    start_pkt(4'd3);
    tx_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (tx_valid) hit = 1'b1;
      else begin
        step();
        settle();
      end
    end
    chk("abh_valid_seen", hit, 1);
    tx_ready = 1'b1;
    abort    = 1'b1;
    #1;
    chk("abh_sent", byte_sent, 1);
    step();
    abort = 1'b0;
    settle();
    chk("abh_busy", busy, 0);
    chk("abh_count", count, 0);
    chk("abh_valid", tx_valid, 0);
    chk("abh_done_cnt", done_cnt, 0);

    // Reset mid-packet beats abort and start.
    reset_mon();
    start_pkt(4'd5);
    repeat (4) step();
    rst   = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    settle();
    chk("mrst_busy", busy, 0);
    chk("mrst_count", count, 0);
    chk("mrst_valid", tx_valid, 0);
    chk("mrst_data", tx_data, 0);

    // Zero-length request is dropped.
    reset_mon();
    step();
    start   = 1'b1;
    pkt_len = 4'd0;
    settle();
    step();
    start = 1'b0;
    settle();
    chk("zero_busy", busy, 0);
    repeat (3) begin
      step();
      settle();
    end
    chk("zero_busy_late", busy, 0);
    chk("zero_rd_cnt", rd_cnt, 0);
    chk("zero_done_cnt", done_cnt, 0);

    // Random lengths, contents and serializer back-pressure.
    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 15);
      fill_mem();
      reset_mon();
      tx_ready = 1'b1;
      start_pkt(4'(len));
      wait_done(400, 1'b1, seen);
      chk("rnd_done_seen", seen, 1);
      tx_ready = 1'b1;
      step();
      settle();
      chk("rnd_count", count, len);
      chk("rnd_busy", busy, 0);
      chk_bytes("rnd", len);
      chk("rnd_rd_cnt", rd_cnt, len);
      chk("rnd_done_cnt", done_cnt, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
